mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the 128-bit line interface driven by the data and instruction caches. It accepts one line read or line write at a time and models a slow memory with a configurable fixed latency. It returns read data and a single-cycle `mem_ready` completion pulse. It sits between the cache's memory port and the backing store in simulation and FPGA test builds.

## Interface
- `LATENCY`, 8: cycles from request acceptance to the `mem_ready` pulse; legal range 1..255.
- `DEPTH_LOG2`, 8: log2 of the number of 128-bit lines stored, so 256 lines by default.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `proc_reset_n`  in  1  synchronous, active-low reset. It is sampled on the rising edge of `clk`.
- `mem_read`  in  1  line read request; level, held by the cache until it sees completion.
- `mem_write`  in  1  line write request; level, held by the cache until it sees completion.
- `mem_addr`  in  28  line address (word address [29:2]).
- `mem_wdata`  in  128  write line; word 0 is in [31:0].
- `mem_rdata`  out  128  read line; registered output.
- `mem_ready`  out  1  completion pulse, exactly one cycle per accepted request; registered output.

## Operation
- Storage is `2^DEPTH_LOG2` lines of 128 bits.
  - The line index is `mem_addr[DEPTH_LOG2-1:0]`.
  - Upper address bits are ignored, so addresses alias modulo the depth.
  - Storage is not cleared by reset; contents survive reset.
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE**
  - If `mem_read` or `mem_write` is 1, latch the request: type, index and `mem_wdata`. Load the counter with `LATENCY-1` and go to BUSY.
  - If both `mem_read` and `mem_write` are 1, the request is accepted as a write.
  - If neither is 1, stay in IDLE.
- **BUSY**
  - Decrement the counter each cycle.
  - When the counter is 0, perform the operation and assert `mem_ready` for the next cycle, then go to DONE.
    - For a write, the latched data is stored to the latched index.
    - For a read, `mem_rdata` is loaded from the latched index.
- **DONE**
  - `mem_ready` is 1 in this state only.
  - Requests are ignored in this state, which covers the cycle where the cache's request is still high.
  - The next state is always IDLE.
- Once accepted, the request parameters are frozen.
  - Changes to `mem_addr`, `mem_wdata`, `mem_read` or `mem_write` during BUSY or DONE have no effect.
  - A request dropped mid-service still completes and still pulses `mem_ready`.
- `mem_rdata` holds its value until the next read completion. Write completions do not change it.

## Timing
- Reset (`proc_reset_n`=0 at an edge):
  - state goes to IDLE;
  - `mem_ready` goes to 0;
  - `mem_rdata` goes to 0;
  - the counter goes to 0.
- Reset asserted during BUSY or DONE aborts the operation:
  - no store occurs if the reset edge coincides with the completion edge;
  - no `mem_ready` pulse is produced.
- Latency: a request sampled in IDLE at edge E0 produces `mem_ready`=1 during the cycle after edge E0+LATENCY.
  - `mem_rdata` is valid in that same cycle, and the write is visible in storage from that edge.
  - With `LATENCY`=1, `mem_ready` follows the accept edge by exactly one edge.
- Throughput:
  - The earliest re-acceptance is the edge after DONE.
  - This matches the cache's pattern of dropping the request one cycle after `mem_ready` and then issuing a follow-on request, such as a write-back followed by an allocate.
- A read to the same line following a completed write returns the new data.
- There is no combinational path from inputs to outputs.

## Test plan
- **Reset.** Hold `proc_reset_n`=0 for 2 cycles with `mem_read`=1 → `mem_ready`=0 and `mem_rdata`=0 throughout, and no pulse appears while reset is held.
- **Write then read (`LATENCY`=4, `DEPTH_LOG2`=4).**
  - Write `mem_addr`=0x0000003, `mem_wdata`=0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA → `mem_ready` pulses 1 cycle, 4 edges after accept.
  - Then read 0x0000003 → `mem_rdata`=that value in the `mem_ready` cycle.
- **Aliasing (`DEPTH_LOG2`=4).** Write 0x1 to line 0x0000015, then read 0x0000005 → returns 0x1.
- **Back-to-back write-back then allocate.**
  - Write A, drop the request the cycle after `mem_ready`, then read B on the next cycle.
  - → Two separate pulses; `mem_rdata` is unchanged after the write pulse.
- **Held or dropped request.**
  - Request kept high through DONE → exactly one pulse, and no re-accept until IDLE.
  - Request dropped after accept → the pulse still occurs and the store still happens.
- **Reset mid-BUSY and simultaneous read/write.**
  - Reset 2 cycles into a write of 0xFF.. to line 7 → no pulse, and a subsequent read of line 7 returns the old data.
  - `mem_read`=`mem_write`=1 → treated as a write.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency 128-bit line memory model answering cache line reads and writes.
// Serves one request at a time and signals completion with a one-cycle mem_ready pulse.
module mem_responder #(
    parameter int unsigned LATENCY    = 8,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic         clk,
    input  logic         proc_reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready
);

    localparam int unsigned Lines = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    is_write_q, is_write_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [127:0]            wdata_q, wdata_d;
    logic [127:0]            rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    mem_we;
    logic [127:0]            mem [Lines];

    // Upper address bits alias by design.
    logic addr_unused;
    assign addr_unused = ^mem_addr;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        mem_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    // A simultaneous read and write is served as a write.
                    is_write_d = mem_write;
                    idx_d      = mem_addr[DEPTH_LOG2-1:0];
                    wdata_d    = mem_wdata;
                    cnt_d      = 8'(LATENCY - 1);
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == 8'd0) begin
                    state_d = StDone;
                    ready_d = 1'b1;
                    if (is_write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
        end
    end

    // Storage is never cleared; a reset on the completion edge suppresses the store.
    always_ff @(posedge clk) begin
        if (proc_reset_n && mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a scoreboard of expected read data per request.
module tb_mem_responder;

    localparam int unsigned LAT = 4;
    localparam int unsigned DL2 = 4;

    logic         clk = 1'b0;
    logic         proc_reset_n;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int checks = 0;
    int errors = 0;

    logic [127:0] model [16];
    logic [127:0] last_rdata;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    mem_responder #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, optionally drop it right after acceptance, and check the completion.
    task automatic run_req(input logic rd, input logic wr, input logic [27:0] a,
                           input logic [127:0] wd, input bit drop_early, input string tag);
        int  k;
        bit  stray;
        logic [127:0] exp;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = wd;
        if (wr) begin
            model[a[DL2-1:0]] = wd;
            exp_q.push_back(last_rdata);
        end else begin
            last_rdata = model[a[DL2-1:0]];
            exp_q.push_back(last_rdata);
        end
        tick();
        // Accepted; disturb the inputs to show the request is frozen.
        if (drop_early) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        mem_addr  = a ^ 28'h5;
        mem_wdata = ~wd;
        k = 0;
        while (mem_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_latency"}, 128'(k), 128'(LAT));
        exp = exp_q.pop_front();
        check({tag, "_rdata"}, mem_rdata, exp);
        tick();
        check({tag, "_single_pulse"}, 128'(mem_ready), 128'(0));
        check({tag, "_rdata_hold"}, mem_rdata, last_rdata);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < int'(LAT) + 2; i++) begin
            tick();
            if (mem_ready !== 1'b0) stray = 1'b1;
        end
        check({tag, "_no_stray"}, 128'(stray), 128'(0));
    endtask

    // Start a write, then reset after the given number of BUSY edges.
    task automatic abort_write(input logic [27:0] a, input logic [127:0] wd,
                               input int edges, input string tag);
        bit early;
        mem_write = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        tick();
        early = 1'b0;
        for (int i = 0; i < edges; i++) begin
            tick();
            if (mem_ready !== 1'b0) early = 1'b1;
        end
        check({tag, "_busy_no_pulse"}, 128'(early), 128'(0));
        proc_reset_n = 1'b0;
        tick();
        check({tag, "_rst_ready"}, 128'(mem_ready), 128'(0));
        check({tag, "_rst_rdata"}, mem_rdata, 128'(0));
        mem_write    = 1'b0;
        proc_reset_n = 1'b1;
        last_rdata   = '0;
        early = 1'b0;
        for (int i = 0; i < int'(LAT) + 2; i++) begin
            tick();
            if (mem_ready !== 1'b0) early = 1'b1;
        end
        check({tag, "_after_no_pulse"}, 128'(early), 128'(0));
    endtask

    initial begin
        proc_reset_n = 1'b0;
        mem_read     = 1'b1;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        last_rdata   = '0;
        for (int i = 0; i < 16; i++) model[i] = 'x;

        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_ready", 128'(mem_ready), 128'(0));
            check("reset_rdata", mem_rdata, 128'(0));
        end
        mem_read     = 1'b0;
        proc_reset_n = 1'b1;
        tick();
        check("post_reset_ready", 128'(mem_ready), 128'(0));

        run_req(1'b0, 1'b1, 28'h0000003, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b0, "wr3");
        run_req(1'b1, 1'b0, 28'h0000003, '0, 1'b0, "rd3");

        run_req(1'b0, 1'b1, 28'h0000015, 128'h1, 1'b0, "wr_alias");
        run_req(1'b1, 1'b0, 28'h0000005, '0, 1'b0, "rd_alias");

        run_req(1'b0, 1'b1, 28'h000000A, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                1'b0, "wb");
        run_req(1'b1, 1'b0, 28'h000000A, '0, 1'b0, "alloc");

        run_req(1'b0, 1'b1, 28'h0000002, 128'hCAFE_F00D, 1'b1, "wr_drop");
        run_req(1'b1, 1'b0, 28'h0000002, '0, 1'b1, "rd_drop");

        run_req(1'b0, 1'b1, 28'h0000007, 128'h7777_0000_7777_0000, 1'b0, "wr7_old");
        abort_write(28'h0000007, '1, 2, "abort_mid");
        run_req(1'b1, 1'b0, 28'h0000007, '0, 1'b0, "rd7_a");
        abort_write(28'h0000007, '1, int'(LAT) - 1, "abort_edge");
        run_req(1'b1, 1'b0, 28'h0000007, '0, 1'b0, "rd7_b");

        run_req(1'b1, 1'b1, 28'h0000009, 128'h9999_AAAA_BBBB_CCCC, 1'b0, "rdwr9");
        run_req(1'b1, 1'b0, 28'h0000009, '0, 1'b0, "rd9");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
